// File: rtl/spi_master_pkg.sv
// Shared types and helpers for the multi-mode SPI master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_TAIL
    } state_e;

    // Type of the SCK edge reported by the divider strobe.
    localparam logic EDGE_LEAD  = 1'b0;
    localparam logic EDGE_TRAIL = 1'b1;

    // Width of the chip-select index; a single CS still needs one bit.
    function automatic int cs_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCK half-period timer: strobes o_tick at the end of every (i_div+1)-cycle half-period.
// Latency: first strobe i_div+1 cycles after i_reload; o_tick/o_edge are combinational from the count.
// Backpressure: none; the counter only runs while i_run is high.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_run enables counting;
//        i_reload restarts the half-period and edge phase; i_div latched half-period - 1;
//        o_tick one-cycle edge strobe; o_edge LEAD/TRAIL type of the strobed edge.
module spi_clk_div
    import spi_master_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic             i_reload,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick,
    output logic             o_edge
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    // The setup half-period is reported as a virtual trailing edge, so the
    // first real SCK edge after it comes out as LEAD and they alternate from there.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        o_tick  = i_run && (cnt_q == i_div);
        o_edge  = ~phase_q;
        if (i_reload) begin
            cnt_d   = '0;
            phase_d = EDGE_LEAD;
        end else if (o_tick) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else if (i_run) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            phase_q <= EDGE_LEAD;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/spi_master_multi.sv
// SPI master with runtime CPOL/CPHA, SCK divider, multiple chip selects and CS-hold bursts.
// Latency: word accepted -> o_rx_valid after (2*DATA_W+1) half-periods + 1 cycle; SS released one half-period later.
// Backpressure: o_ready high only in IDLE and HOLD; the bus side waits otherwise.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_cpol/i_cpha/i_div/i_cs_sel/i_hold
//        word options sampled at accept; i_valid/o_ready/i_data TX word handshake;
//        o_rx_valid/o_rx_data received word; o_busy some SS asserted; spi_* board pins.
// Optional: define SPI_LSB_FIRST_EN to add i_lsb_first (LSB-first shifting per word).
module spi_master_multi
    import spi_master_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int NUM_CS = 1,
    parameter  int DIV_W  = 8,
    localparam int CS_W   = cs_width(NUM_CS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpol,
    input  logic              i_cpha,
    input  logic [DIV_W-1:0]  i_div,
    input  logic [CS_W-1:0]   i_cs_sel,
    input  logic              i_hold,
`ifdef SPI_LSB_FIRST_EN
    input  logic              i_lsb_first,
`endif
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_rx_valid,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_busy,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_CS-1:0] spi_ss
);

    localparam int EC_W = $clog2(2 * DATA_W);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  tx_q, tx_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_vld_q, rx_vld_d;
    logic               mosi_q, mosi_d;
    logic               sck_q, sck_d;
    logic [NUM_CS-1:0]  ss_q, ss_d;
    logic               cpha_q, cpha_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               hold_q, hold_d;
    logic               lsb_q, lsb_d;
    logic [EC_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic               out_en_q;

    logic               lsb_in;
    logic               tick, edge_type, run, reload;
    logic               accept, is_samp, first_edge, last_edge, samp_edge, shift_edge;
    logic [DATA_W-1:0]  tx_shift, rx_shift;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = i_lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    // out_en_q keeps o_ready low while reset is applied, even though the
    // state register already sits in IDLE.
    assign o_ready    = out_en_q && (state_q == ST_IDLE || state_q == ST_HOLD);
    assign accept     = i_valid && o_ready;
    assign run        = (state_q == ST_SETUP) || (state_q == ST_XFER) || (state_q == ST_TAIL);

    assign is_samp    = (edge_type == (cpha_q ? EDGE_TRAIL : EDGE_LEAD));
    assign first_edge = (edge_cnt_q == '0);
    assign last_edge  = (edge_cnt_q == EC_W'(2 * DATA_W - 1));
    assign samp_edge  = tick && is_samp;
    // CPHA=1 already presents the first bit at accept, so its first leading
    // edge has nothing new to shift; CPHA=0 must not shift past the last bit.
    assign shift_edge = tick && !is_samp && !last_edge && !(cpha_q && first_edge);

    assign tx_shift   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
    assign rx_shift   = lsb_q ? {spi_miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], spi_miso};

    spi_clk_div #(
        .DIV_W (DIV_W)
    ) u_clk_div (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_run    (run),
        .i_reload (reload),
        .i_div    (div_q),
        .o_tick   (tick),
        .o_edge   (edge_type)
    );

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rx_data_d  = rx_data_q;
        rx_vld_d   = 1'b0;
        mosi_d     = mosi_q;
        sck_d      = sck_q;
        ss_d       = ss_q;
        cpha_d     = cpha_q;
        div_d      = div_q;
        hold_d     = hold_q;
        lsb_d      = lsb_q;
        edge_cnt_d = edge_cnt_q;
        reload     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sck_d = i_cpol;
                // Mode and chip select are only taken from a fresh burst;
                // an out-of-range select leaves every SS high.
                if (accept) begin
                    cpha_d = i_cpha;
                    for (int i = 0; i < NUM_CS; i++) begin
                        ss_d[i] = (i_cs_sel != CS_W'(i));
                    end
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (tick) begin
                    sck_d      = ~sck_q;
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    if (samp_edge) begin
                        rx_d = rx_shift;
                    end
                    if (shift_edge) begin
                        tx_d   = tx_shift;
                        mosi_d = lsb_q ? tx_shift[0] : tx_shift[DATA_W-1];
                    end
                    if (last_edge) begin
                        rx_data_d = samp_edge ? rx_shift : rx_q;
                        rx_vld_d  = 1'b1;
                        if (hold_q) begin
                            state_d = ST_HOLD;
                        end else begin
                            state_d = ST_TAIL;
                            reload  = 1'b1;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (!i_valid && !i_hold) begin
                    state_d = ST_TAIL;
                    reload  = 1'b1;
                end
            end
            ST_TAIL: begin
                if (tick) begin
                    ss_d    = '1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Per-word fields, common to a new burst and to a continuation in HOLD.
        if (accept) begin
            tx_d       = i_data;
            mosi_d     = lsb_in ? i_data[0] : i_data[DATA_W-1];
            rx_d       = '0;
            div_d      = i_div;
            hold_d     = i_hold;
            lsb_d      = lsb_in;
            edge_cnt_d = '0;
            state_d    = ST_SETUP;
            reload     = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            rx_data_q  <= '0;
            rx_vld_q   <= 1'b0;
            mosi_q     <= 1'b0;
            sck_q      <= 1'b0;
            ss_q       <= '1;
            cpha_q     <= 1'b0;
            div_q      <= '0;
            hold_q     <= 1'b0;
            lsb_q      <= 1'b0;
            edge_cnt_q <= '0;
            out_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rx_data_q  <= rx_data_d;
            rx_vld_q   <= rx_vld_d;
            mosi_q     <= mosi_d;
            sck_q      <= sck_d;
            ss_q       <= ss_d;
            cpha_q     <= cpha_d;
            div_q      <= div_d;
            hold_q     <= hold_d;
            lsb_q      <= lsb_d;
            edge_cnt_q <= edge_cnt_d;
            out_en_q   <= 1'b1;
        end
    end

    assign o_rx_valid = rx_vld_q;
    assign o_rx_data  = rx_data_q;
    assign o_busy     = ~&ss_q;
    assign spi_sck    = sck_q;
    assign spi_mosi   = mosi_q;
    assign spi_ss     = ss_q;

endmodule
